// File: rtl/cache_pkg.sv
// Shared definitions for the cache replacement-policy slice.
//  - POLICY_LRU / POLICY_PLRU select the per-set replacement state format.
//  - clog2 and state_width size the per-set state word.
//  - is_onehot, onehot_to_idx and idx_to_onehot convert way selects. They
//    operate on 16-bit vectors, which covers the largest supported
//    associativity (16 ways).
package cache_pkg;

    localparam int unsigned POLICY_LRU  = 0;
    localparam int unsigned POLICY_PLRU = 1;
    localparam int unsigned MAX_WAYS    = 16;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) r++;
        return r;
    endfunction

    // LRU keeps one age rank per way; PLRU keeps one bit per internal tree node.
    function automatic int unsigned state_width(input int unsigned ways,
                                                input int unsigned policy);
        return (policy == POLICY_PLRU) ? (ways - 1) : (ways * clog2(ways));
    endfunction

    // Zero is treated as not one-hot.
    function automatic logic is_onehot(input logic [MAX_WAYS-1:0] v);
        return (v != '0) && ((v & (v - 16'd1)) == '0);
    endfunction

    function automatic logic [3:0] onehot_to_idx(input logic [MAX_WAYS-1:0] v);
        logic [3:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < MAX_WAYS; i++)
            if (v[i]) idx = 4'(i);
        return idx;
    endfunction

    function automatic logic [MAX_WAYS-1:0] idx_to_onehot(input logic [3:0] idx);
        return 16'd1 << idx;
    endfunction

endpackage

// File: rtl/replacement_policy_unit_plru_tree_next.sv
// Tree pseudo-LRU logic for one set.
//  bits_cur    current node bits, heap order (node n has children 2n+1, 2n+2)
//  way_idx     binary index of the way being touched / invalidated
//  toward      0: path nodes point away from way_idx (access)
//              1: path nodes point toward way_idx (invalidate)
//  bits_next   updated node bits
//  victim_idx  way reached by following the current bits (0 -> left)
module plru_tree_next
    import cache_pkg::*;
#(
    parameter int unsigned WAYS = 4,
    localparam int unsigned IW  = (WAYS > 1) ? clog2(WAYS) : 1
) (
    input  logic [WAYS-2:0] bits_cur,
    input  logic [IW-1:0]   way_idx,
    input  logic            toward,
    output logic [WAYS-2:0] bits_next,
    output logic [IW-1:0]   victim_idx
);

    always_comb begin
        int unsigned n;
        logic        d;
        bits_next  = bits_cur;
        victim_idx = '0;

        // Way index MSB selects the branch at the root.
        n = 0;
        for (int unsigned l = 0; l < IW; l++) begin
            d            = way_idx[IW-1-l];
            bits_next[n] = toward ? d : ~d;
            n            = 2 * n + 1 + {31'd0, d};
        end

        n = 0;
        for (int unsigned l = 0; l < IW; l++) begin
            d                   = bits_cur[n];
            victim_idx[IW-1-l]  = d;
            n                   = 2 * n + 1 + {31'd0, d};
        end
    end

endmodule

// File: rtl/replacement_policy_unit.sv
// Victim selection and recency tracking for an N-way set-associative cache.
//  clk, reset      clock; synchronous active-high reset
//  index           set for update / invalidate / victim query
//  valid_mask      valid bits of the addressed set
//  update_en       record hit/fill on one-hot access_way
//  inv_en          invalidate one-hot inv_way (becomes next victim)
//  victim_way      one-hot replacement choice for index
//  victim_ok       victim_way meaningful (low during init sweep)
//  busy            init sweep in progress
//  onehot_err      sticky flag: enabled access_way/inv_way was not one-hot
module replacement_policy_unit
    import cache_pkg::*;
#(
    parameter int unsigned WAYS   = 4,
    parameter int unsigned SETS   = 128,
    parameter int unsigned POLICY = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [clog2(SETS)-1:0]   index,
    input  logic [WAYS-1:0]          valid_mask,
    input  logic                     update_en,
    input  logic [WAYS-1:0]          access_way,
    input  logic                     inv_en,
    input  logic [WAYS-1:0]          inv_way,
    output logic [WAYS-1:0]          victim_way,
    output logic                     victim_ok,
    output logic                     busy,
    output logic                     onehot_err
);

    localparam int unsigned IW  = clog2(WAYS);
    localparam int unsigned SIW = clog2(SETS);
    localparam int unsigned SW  = state_width(WAYS, POLICY);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t           state, state_nxt;
    logic [SIW-1:0]   ptr, ptr_nxt;
    logic             err_nxt;

    logic [SW-1:0]    mem [SETS];
    logic [SW-1:0]    rd_state;
    logic [SW-1:0]    init_state;
    logic [SW-1:0]    pol_next;
    logic [IW-1:0]    pol_victim;

    logic             wr_en;
    logic [SIW-1:0]   wr_addr;
    logic [SW-1:0]    wr_data;

    logic             acc_ok, inv_ok, is_inv;
    logic [IW-1:0]    way_sel;

    // Victims and updates always see the stored value, so back-to-back
    // writes to one set chain through the array without forwarding.
    assign rd_state = mem[index];
    assign acc_ok   = is_onehot(16'(access_way));
    assign inv_ok   = is_onehot(16'(inv_way));

    always_comb begin
        logic [3:0] idx;
        is_inv  = !update_en;
        idx     = update_en ? onehot_to_idx(16'(access_way)) : onehot_to_idx(16'(inv_way));
        way_sel = IW'(idx);
    end

    generate
        if (POLICY == POLICY_PLRU) begin : g_plru
            assign init_state = '0;
            plru_tree_next #(.WAYS(WAYS)) u_tree (
                .bits_cur   (rd_state),
                .way_idx    (way_sel),
                .toward     (is_inv),
                .bits_next  (pol_next),
                .victim_idx (pol_victim)
            );
        end else begin : g_lru
            always_comb begin
                init_state = '0;
                for (int unsigned i = 0; i < WAYS; i++)
                    init_state[i*IW +: IW] = IW'(i);
            end

            always_comb begin
                logic [IW-1:0] a, age;
                pol_next   = rd_state;
                pol_victim = '0;
                a          = rd_state[way_sel*IW +: IW];
                for (int unsigned i = 0; i < WAYS; i++) begin
                    age = rd_state[i*IW +: IW];
                    if (age == IW'(WAYS - 1))
                        pol_victim = IW'(i);
                    if (IW'(i) == way_sel)
                        pol_next[i*IW +: IW] = is_inv ? IW'(WAYS - 1) : '0;
                    else if (!is_inv && age < a)
                        pol_next[i*IW +: IW] = age + IW'(1);
                    else if (is_inv && age > a)
                        pol_next[i*IW +: IW] = age - IW'(1);
                end
            end
        end
    endgenerate

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        err_nxt   = onehot_err;
        wr_en     = 1'b0;
        wr_addr   = index;
        wr_data   = pol_next;
        busy      = 1'b0;
        case (state)
            ST_INIT: begin
                busy    = 1'b1;
                wr_en   = 1'b1;
                wr_addr = ptr;
                wr_data = init_state;
                ptr_nxt = ptr + SIW'(1);
                if (ptr == SIW'(SETS - 1))
                    state_nxt = ST_RUN;
            end
            ST_RUN: begin
                // Update has priority; a concurrent invalidate is dropped.
                if (update_en)
                    wr_en = acc_ok;
                else if (inv_en)
                    wr_en = inv_ok;
                if ((update_en && !acc_ok) || (inv_en && !inv_ok))
                    err_nxt = 1'b1;
            end
            default: state_nxt = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_INIT;
            ptr        <= '0;
            onehot_err <= 1'b0;
        end else begin
            state      <= state_nxt;
            ptr        <= ptr_nxt;
            onehot_err <= err_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

    always_comb begin
        logic          found;
        logic [IW-1:0] sel;
        found = 1'b0;
        sel   = pol_victim;
        for (int unsigned i = 0; i < WAYS; i++) begin
            if (!found && !valid_mask[i]) begin
                found = 1'b1;
                sel   = IW'(i);
            end
        end
        victim_ok  = (state == ST_RUN);
        victim_way = victim_ok ? WAYS'(idx_to_onehot(4'(sel))) : '0;
    end

endmodule
